// File: rtl/nnlut_act_vec.sv
// nnlut_act_vec: programmable piecewise-linear activation over DIMENTION lanes.
// One loadable table (breakpoints, k, b) is shared by all lanes. Three-stage
// pipeline: S1 segment select, S2 k*x+b, S3 round/shift/saturate into act.
// Optional macro NNLUT_SAT_CNT_EN adds a sticky 16-bit saturated-lane counter.
module nnlut_act_vec #(
  parameter int DIMENTION    = 64,
  parameter int X_WIDTH      = 8,
  parameter int K_WIDTH      = 32,
  parameter int B_WIDTH      = 32,
  parameter int BP_NUM       = 16,
  parameter int OUT_WIDTH    = 8,
  parameter int RESULT_WIDTH = X_WIDTH + K_WIDTH + 1,
  parameter int SH_WIDTH     = $clog2(RESULT_WIDTH)
) (
  input  logic                           clk_p,
  input  logic                           rst_n,
  input  logic [X_WIDTH*DIMENTION-1:0]   x,
  input  logic [SH_WIDTH-1:0]            shift_amt,
  input  logic                           input_valid_n,
  output logic                           input_ready,
  output logic [OUT_WIDTH*DIMENTION-1:0] act,
  output logic                           act_valid_n,
  input  logic                           act_ready,
  input  logic                           tbl_wr_en,
  input  logic [1:0]                     tbl_sel,
  input  logic [$clog2(BP_NUM)-1:0]      tbl_addr,
  input  logic [K_WIDTH-1:0]             tbl_data,
  output logic                           tbl_wr_err
`ifdef NNLUT_SAT_CNT_EN
  ,
  output logic [15:0]                    sat_cnt
`endif
);

  localparam int SEG_W = $clog2(BP_NUM);
  localparam logic signed [RESULT_WIDTH:0] SAT_HI = (RESULT_WIDTH+1)'((2**(OUT_WIDTH-1)) - 1);
  localparam logic signed [RESULT_WIDTH:0] SAT_LO = ~SAT_HI;
  localparam logic [SH_WIDTH-1:0] SH_MAX = SH_WIDTH'(RESULT_WIDTH - 1);

  logic signed [X_WIDTH-1:0] bp_tbl [BP_NUM];
  logic signed [K_WIDTH-1:0] k_tbl  [BP_NUM];
  logic signed [B_WIDTH-1:0] b_tbl  [BP_NUM];

  logic s1_v, s2_v, s3_v;
  logic stall, xfer;
  logic wr_ignored, wr_ok;
  logic [SH_WIDTH-1:0] sh_c, sh1, sh2;
  logic signed [RESULT_WIDTH:0] rnd_c;
  logic [DIMENTION-1:0] sat_flag;

  // the whole pipeline freezes only when a finished vector is not taken
  assign stall       = s3_v & ~act_ready;
  assign input_ready = ~stall;
  assign xfer        = ~input_valid_n & ~stall;
  assign act_valid_n = ~s3_v;

  // bp[0] has no meaning (segment 0 is everything below bp[1]) and sel 3 is reserved
  assign wr_ignored = (tbl_sel == 2'd3) || (tbl_sel == 2'd0 && tbl_addr == '0);
  assign wr_ok      = tbl_wr_en & ~wr_ignored & ~s1_v & ~s2_v & ~s3_v & ~xfer;
  assign sh_c       = (shift_amt > SH_MAX) ? SH_MAX : shift_amt;

  // table storage, only rewritten while no vector can observe it
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BP_NUM; i++) begin
        bp_tbl[i] <= '0;
        k_tbl[i]  <= '0;
        b_tbl[i]  <= '0;
      end
    end else if (wr_ok) begin
      case (tbl_sel)
        2'd0:    bp_tbl[tbl_addr] <= tbl_data[X_WIDTH-1:0];
        2'd1:    k_tbl[tbl_addr]  <= tbl_data;
        default: b_tbl[tbl_addr]  <= tbl_data[B_WIDTH-1:0];
      endcase
    end
  end

  // rejected writes report back one cycle later
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) tbl_wr_err <= 1'b0;
    else        tbl_wr_err <= tbl_wr_en & ~wr_ignored & ~wr_ok;
  end

  // stage valids and the per-vector shift travelling alongside the data
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
      sh1  <= '0;
      sh2  <= '0;
    end else if (!stall) begin
      s1_v <= xfer;
      s2_v <= s1_v;
      s3_v <= s2_v;
      if (xfer) sh1 <= sh_c;
      if (s1_v) sh2 <= sh1;
    end
  end

  // round-half-up bias for the S3 shift, shared by every lane
  always_comb begin
    rnd_c = '0;
    if (sh2 != '0) rnd_c = (RESULT_WIDTH+1)'(1) << (sh2 - SH_WIDTH'(1));
  end

  for (genvar i = 0; i < DIMENTION; i++) begin : g_lane
    logic signed [X_WIDTH-1:0]      xi, x1;
    logic [SEG_W-1:0]               seg_c, seg1;
    logic signed [RESULT_WIDTH-1:0] mac_c, r2;
    logic signed [RESULT_WIDTH:0]   sum_c, q_c;
    logic [OUT_WIDTH-1:0]           sat_c, act_q;
    logic                           hit_c;

    assign xi = x[i*X_WIDTH +: X_WIDTH];

    // segment = number of breakpoints at or below x; any bp ordering is legal
    always_comb begin
      seg_c = '0;
      for (int j = 1; j < BP_NUM; j++)
        if (xi >= bp_tbl[j]) seg_c = seg_c + SEG_W'(1);
    end

    assign mac_c = RESULT_WIDTH'(k_tbl[seg1]) * RESULT_WIDTH'(x1) + RESULT_WIDTH'(b_tbl[seg1]);

    // one extra bit keeps the rounding add clear of overflow
    always_comb begin
      sum_c = $signed({r2[RESULT_WIDTH-1], r2}) + rnd_c;
      q_c   = sum_c >>> sh2;
      hit_c = 1'b1;
      if (q_c > SAT_HI)      sat_c = SAT_HI[OUT_WIDTH-1:0];
      else if (q_c < SAT_LO) sat_c = SAT_LO[OUT_WIDTH-1:0];
      else begin
        sat_c = q_c[OUT_WIDTH-1:0];
        hit_c = 1'b0;
      end
    end

    // lane datapath registers; each stage loads only when fed a valid vector
    always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
        x1    <= '0;
        seg1  <= '0;
        r2    <= '0;
        act_q <= '0;
      end else if (!stall) begin
        if (xfer) begin
          x1   <= xi;
          seg1 <= seg_c;
        end
        if (s1_v) r2    <= mac_c;
        if (s2_v) act_q <= sat_c;
      end
    end

    assign act[i*OUT_WIDTH +: OUT_WIDTH] = act_q;
    assign sat_flag[i] = hit_c;
  end

`ifdef NNLUT_SAT_CNT_EN
  logic [16:0] pop_c, sum_cnt_c;

  // lanes clipped in the vector about to land in act
  always_comb begin
    pop_c = '0;
    for (int i = 0; i < DIMENTION; i++) pop_c = pop_c + 17'(sat_flag[i]);
    sum_cnt_c = {1'b0, sat_cnt} + pop_c;
  end

  // sticky at all-ones; counts once per S3 load, never during a hold
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n)              sat_cnt <= '0;
    else if (!stall && s2_v) sat_cnt <= sum_cnt_c[16] ? 16'hFFFF : sum_cnt_c[15:0];
  end
`endif

endmodule

// File: tb/tb_nnlut_act_vec.sv
module tb_nnlut_act_vec;
  localparam int D   = 8;
  localparam int XW  = 8;
  localparam int KW  = 32;
  localparam int BPN = 16;
  localparam int OW  = 8;
  localparam int RW  = XW + KW + 1;
  localparam int SHW = $clog2(RW);
  localparam int AW  = $clog2(BPN);

  logic              clk_p, rst_n;
  logic [XW*D-1:0]   x;
  logic [SHW-1:0]    shift_amt;
  logic              input_valid_n, input_ready;
  logic [OW*D-1:0]   act;
  logic              act_valid_n, act_ready;
  logic              tbl_wr_en;
  logic [1:0]        tbl_sel;
  logic [AW-1:0]     tbl_addr;
  logic [KW-1:0]     tbl_data;
  logic              tbl_wr_err;
`ifdef NNLUT_SAT_CNT_EN
  logic [15:0]       sat_cnt;
`endif

  nnlut_act_vec #(.DIMENTION(D), .X_WIDTH(XW), .K_WIDTH(KW), .B_WIDTH(32),
                  .BP_NUM(BPN), .OUT_WIDTH(OW)) dut (
    .clk_p(clk_p), .rst_n(rst_n), .x(x), .shift_amt(shift_amt),
    .input_valid_n(input_valid_n), .input_ready(input_ready),
    .act(act), .act_valid_n(act_valid_n), .act_ready(act_ready),
    .tbl_wr_en(tbl_wr_en), .tbl_sel(tbl_sel), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .tbl_wr_err(tbl_wr_err)
`ifdef NNLUT_SAT_CNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  initial clk_p = 1'b0;
  always #5 clk_p = ~clk_p;

  // reference model: table contents and vectors in flight with their age
  typedef struct { logic [OW*D-1:0] val; int age; int nsat; } item_t;
  int          bp_m [BPN];
  longint      k_m  [BPN];
  longint      b_m  [BPN];
  item_t       q[$];
  logic [OW*D-1:0] last_act;
  logic        err_exp;
  int          sat_m;
  bit          last_xfer;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < BPN; i++) begin bp_m[i] = 0; k_m[i] = 0; b_m[i] = 0; end
    last_act = '0;
    err_exp  = 1'b0;
    sat_m    = 0;
  endtask

  function automatic void model_vec(input logic [XW*D-1:0] xv, input int sh,
                                    output logic [OW*D-1:0] v, output int nsat);
    int xi, seg, shc;
    longint r;
    logic [63:0] rb;
    nsat = 0;
    v = '0;
    shc = (sh > RW - 1) ? RW - 1 : sh;
    for (int l = 0; l < D; l++) begin
      xi = int'($signed(xv[l*XW +: XW]));
      seg = 0;
      for (int j = 1; j < BPN; j++) if (xi >= bp_m[j]) seg++;
      r = k_m[seg] * longint'(xi) + b_m[seg];
      if (shc > 0) r = (r + (longint'(1) <<< (shc - 1))) >>> shc;
      if (r > (2**(OW-1)) - 1) begin r = (2**(OW-1)) - 1; nsat++; end
      else if (r < -(2**(OW-1))) begin r = -(2**(OW-1)); nsat++; end
      rb = r;
      v[l*OW +: OW] = rb[OW-1:0];
    end
  endfunction

  // one clock: check outputs mid-cycle, predict the edge, advance
  task automatic step();
    bit vexp, stl, xf, ign, wok;
    logic [OW*D-1:0] v;
    int ns;
    logic [KW-1:0] d;
    #4;
    vexp = (q.size() > 0) && (q[0].age >= 3);
    stl  = vexp && !act_ready;
    chk("act_valid_n", act_valid_n, !vexp);
    chk("input_ready", input_ready, !stl);
    chk("act", act, vexp ? q[0].val : last_act);
    chk("tbl_wr_err", tbl_wr_err, err_exp);
`ifdef NNLUT_SAT_CNT_EN
    chk("sat_cnt", sat_cnt, sat_m);
`endif
    xf  = !input_valid_n && !stl;
    ign = (tbl_sel == 2'd3) || (tbl_sel == 2'd0 && tbl_addr == '0);
    wok = tbl_wr_en && !ign && (q.size() == 0) && !xf;
    err_exp = tbl_wr_en && !ign && !wok;
    d = tbl_data;
    if (wok) begin
      case (tbl_sel)
        2'd0:    bp_m[tbl_addr] = int'($signed(d[XW-1:0]));
        2'd1:    k_m[tbl_addr]  = longint'($signed(d));
        default: b_m[tbl_addr]  = longint'($signed(d));
      endcase
    end
    if (!stl) begin
      if (vexp) begin last_act = q[0].val; void'(q.pop_front()); end
      foreach (q[i]) begin
        q[i].age++;
        if (q[i].age == 3) sat_m = (sat_m + q[i].nsat > 65535) ? 65535 : sat_m + q[i].nsat;
      end
      if (xf) begin
        model_vec(x, int'(shift_amt), v, ns);
        q.push_back('{val: v, age: 1, nsat: ns});
      end
    end
    last_xfer = xf;
    @(posedge clk_p);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [1:0] sel, input int addr, input logic [KW-1:0] data);
    tbl_wr_en = 1'b1; tbl_sel = sel; tbl_addr = AW'(addr); tbl_data = data;
    step();
    tbl_wr_en = 1'b0;
  endtask

  task automatic set_all(input logic [1:0] sel, input logic [KW-1:0] data);
    for (int a = 0; a < BPN; a++) wr(sel, a, data);
  endtask

  task automatic send(input logic [XW*D-1:0] xv, input int sh);
    int tries = 0;
    x = xv; shift_amt = SHW'(sh); input_valid_n = 1'b0;
    do begin step(); tries++; end while (!last_xfer && tries < 50);
    chk("send_accepted", last_xfer, 1'b1);
    input_valid_n = 1'b1;
  endtask

  function automatic logic [XW*D-1:0] pack4(input int a, input int b, input int c, input int e);
    int v [4];
    logic [XW*D-1:0] r;
    v = '{a, b, c, e};
    for (int l = 0; l < D; l++) r[l*XW +: XW] = XW'(v[l % 4]);
    return r;
  endfunction

  initial begin
    int sent, cyc;
    rst_n = 1'b0; x = '0; shift_amt = '0; input_valid_n = 1'b1; act_ready = 1'b1;
    tbl_wr_en = 1'b0; tbl_sel = '0; tbl_addr = '0; tbl_data = '0;
    model_clear();
    #3;
    chk("reset_act_valid_n", act_valid_n, 1'b1);
    chk("reset_act", act, '0);
    chk("reset_input_ready", input_ready, 1'b1);
    chk("reset_tbl_wr_err", tbl_wr_err, 1'b0);
    @(posedge clk_p); #1;
    rst_n = 1'b1;
    idle(2);

    // identity
    set_all(2'd1, 256);
    send(pack4(5, -7, 127, -128), 8);
    idle(5);

    // ReLU via breakpoints
    wr(2'd0, 1, 0);
    for (int a = 2; a < BPN; a++) wr(2'd0, a, 127);
    set_all(2'd1, 0);
    wr(2'd1, 1, 256);
    send(pack4(-3, 0, 9, 127), 8);
    idle(4);

    // rounding and saturation
    set_all(2'd1, 3);
    send(pack4(1, -1, 1, -1), 1);
    idle(4);
    set_all(2'd1, 32'd1 << 20);
    send(pack4(100, -100, 100, -100), 8);
    idle(4);

    // backpressure
    set_all(2'd1, 256);
    sent = 0; cyc = 0; shift_amt = 8;
    while (cyc < 30) begin
      act_ready = !(cyc >= 4 && cyc <= 8);
      input_valid_n = (sent < 6) ? 1'b0 : 1'b1;
      x = pack4(sent, -sent, 2 * sent, 50 + sent);
      step();
      if (last_xfer) sent++;
      cyc++;
    end
    chk("bp_vectors_sent", sent, 6);
    input_valid_n = 1'b1; act_ready = 1'b1;
    idle(4);

    // write while busy is rejected, write while idle is taken
    send(pack4(9, 9, 9, 9), 8);
    wr(2'd1, 1, 512);
    idle(4);
    wr(2'd1, 1, 512);
    idle(1);
    send(pack4(9, 9, 9, 9), 8);
    idle(4);

    // reset with three vectors in flight
    x = pack4(9, 20, -5, 100); shift_amt = 8; input_valid_n = 1'b0;
    idle(3);
    input_valid_n = 1'b1;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("midrst_act_valid_n", act_valid_n, 1'b1);
    chk("midrst_act", act, '0);
    chk("midrst_input_ready", input_ready, 1'b1);
    chk("midrst_tbl_wr_err", tbl_wr_err, 1'b0);
    @(posedge clk_p); #1;
    rst_n = 1'b1;
    send(pack4(9, 20, -5, 100), 8);
    idle(4);

    // random tables and traffic
    for (int a = 0; a < BPN; a++) begin
      wr(2'd0, a, $urandom);
      wr(2'd1, a, $urandom);
      wr(2'd2, a, $urandom);
    end
    for (int i = 0; i < 200; i++) begin
      for (int l = 0; l < D; l++) x[l*XW +: XW] = XW'($urandom);
      shift_amt     = SHW'($urandom_range(0, 63));
      input_valid_n = ($urandom_range(0, 3) == 0);
      act_ready     = ($urandom_range(0, 3) != 0);
      tbl_wr_en     = ($urandom_range(0, 7) == 0);
      tbl_sel       = 2'($urandom_range(0, 3));
      tbl_addr      = AW'($urandom);
      tbl_data      = $urandom;
      step();
    end
    tbl_wr_en = 1'b0; input_valid_n = 1'b1; act_ready = 1'b1;
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
